// File: rtl/konami_sequencer_if.sv
// konami_sequencer_if
//   Bundles the six raw push-button levels and the display-side outputs of
//   the Konami code sequencer.
//   master : drives the buttons, observes state/unlock (board or testbench)
//   slave  : the sequencer itself
//   Signals:
//     btn_up/down/left/right/b/a : raw levels, 1 = pressed, asynchronous to clk
//     state[3:0]                 : display code (0 idle, 1-8 progress, 9 success, 10 error)
//     unlock                     : one-cycle pulse on entry to success
interface konami_sequencer_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_b;
  logic       btn_a;
  logic [3:0] state;
  logic       unlock;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_b, btn_a,
    input  state, unlock
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_b, btn_a,
    output state, unlock
  );
endinterface

// File: rtl/konami_sequencer.sv
// konami_sequencer
//   Tracks entry of the Konami code (up up down down left right left right B A)
//   from six raw push-buttons. Each button passes through a two-flop
//   synchronizer and a rising-edge detector; the FSM then checks one press at a
//   time against the expected key, with an inter-press timeout and a timed
//   success/error display.
//
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : konami_sequencer_if.slave (buttons in, state/unlock out)
//
//   Parameters:
//     TIMEOUT_CYCLES : idle cycles tolerated between presses during entry
//     HOLD_CYCLES    : cycles SUCCESS/ERROR stays on the display
//     CNT_W          : shared counter width, >= clog2 of both of the above
//
//   Optional feature macro: KONAMI_RESTART_EN
//     When defined, a single wrong "up" press part-way through the code
//     restarts entry at S1 instead of going to ERROR.
module konami_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned HOLD_CYCLES    = 100000000,
  parameter int unsigned CNT_W          = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  konami_sequencer_if.slave  bus
);

  // Press vector bit order: {up, down, left, right, b, a}
  localparam logic [5:0] K_UP    = 6'b100000;
  localparam logic [5:0] K_DOWN  = 6'b010000;
  localparam logic [5:0] K_LEFT  = 6'b001000;
  localparam logic [5:0] K_RIGHT = 6'b000100;
  localparam logic [5:0] K_B     = 6'b000010;
  localparam logic [5:0] K_A     = 6'b000001;

  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

`ifdef KONAMI_RESTART_EN
  localparam bit RESTART_EN = 1'b1;
`else
  localparam bit RESTART_EN = 1'b0;
`endif

  // Encoding is chosen so that "next correct state" is simply +1 from
  // IDLE through B_SEEN into SUCCESS.
  typedef enum logic [3:0] {
    ST_IDLE, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_S8,
    ST_B_SEEN, ST_SUCCESS, ST_ERROR
  } fsm_e;

  function automatic logic [5:0] expected_key(input fsm_e s);
    case (s)
      ST_IDLE, ST_S1: expected_key = K_UP;
      ST_S2, ST_S3:   expected_key = K_DOWN;
      ST_S4, ST_S6:   expected_key = K_LEFT;
      ST_S5, ST_S7:   expected_key = K_RIGHT;
      ST_S8:          expected_key = K_B;
      ST_B_SEEN:      expected_key = K_A;
      default:        expected_key = 6'b000000;
    endcase
  endfunction

  function automatic logic [3:0] state_code(input fsm_e s);
    case (s)
      ST_B_SEEN:  state_code = 4'd8;
      ST_SUCCESS: state_code = 4'd9;
      ST_ERROR:   state_code = 4'd10;
      default:    state_code = 4'(s); // IDLE..S8 map to 0..8 directly
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Input path: synchronizer, previous-value flop, edge detect
  // ---------------------------------------------------------------------------
  logic [5:0] raw;
  logic [5:0] sync1_q, sync1_d;
  logic [5:0] sync2_q, sync2_d;
  logic [5:0] prev_q,  prev_d;
  logic [1:0] warm_q,  warm_d;
  logic [5:0] press;
  logic       press_any;
  logic       press_single;

  assign raw = {bus.btn_up, bus.btn_down, bus.btn_left,
                bus.btn_right, bus.btn_b, bus.btn_a};

  // NOTE: every variable written in an always_comb gets a default first, so
  //       no path can leave it unassigned and infer a latch.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    // warm_q masks presses until the synchronizer has refilled after reset,
    // so a button held through reset deassertion is not seen as a new press.
    warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
  end

  assign press        = (warm_q == 2'd3) ? (sync2_q & ~prev_q) : 6'b000000;
  assign press_any    = |press;
  assign press_single = $onehot(press);

  // NOTE: sequential state is written with non-blocking assignments only, so
  //       every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      warm_q  <= warm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with shared timeout/hold counter
  // ---------------------------------------------------------------------------
  fsm_e             fsm_q,    fsm_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [3:0]       code_q,   code_d;
  logic             unlock_q, unlock_d;

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    case (fsm_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Wrong or simultaneous keys are ignored while idle.
        if (press_single && press == K_UP) fsm_d = ST_S1;
      end
      ST_SUCCESS, ST_ERROR: begin
        // Presses are ignored here and never restart the hold time.
        if (cnt_q == HOLD_LAST) fsm_d = ST_IDLE;
        else                    cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        // A press always wins over a timeout expiring in the same cycle.
        if (press_any) begin
          if (press_single && press == expected_key(fsm_q))
            fsm_d = fsm_e'(fsm_q + 4'd1);
          else if (RESTART_EN && press_single && press == K_UP)
            fsm_d = ST_S1;
          else
            fsm_d = ST_ERROR;
        end else if (cnt_q == TMO_LAST) begin
          fsm_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
    // Every transition restarts timing; in entry states every press causes a
    // transition, so this also covers clearing on a press.
    if (fsm_d != fsm_q) cnt_d = '0;

    code_d   = state_code(fsm_d);
    unlock_d = (fsm_d == ST_SUCCESS) && (fsm_q != ST_SUCCESS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= ST_IDLE;
      cnt_q    <= '0;
      code_q   <= 4'd0;
      unlock_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      unlock_q <= unlock_d;
    end
  end

  assign bus.state  = code_q;
  assign bus.unlock = unlock_q;

endmodule
